// File: rtl/ram_arbiter_pkg.sv
// Purpose: shared constants and types for the data-RAM arbiter.
//   ARB_M0/ARB_M1      : requester identifiers (read-owner encoding)
//   ARB_MAX_HOLD_DEF   : default starvation limit
//   WE_W / mem_wen_t   : byte write-strobe width and type
//   cnt_width()        : width of a counter that must reach max_hold
package ram_arbiter_pkg;

  localparam logic        ARB_M0           = 1'b0;
  localparam logic        ARB_M1           = 1'b1;
  localparam int unsigned ARB_MAX_HOLD_DEF = 8;
  localparam int unsigned WE_W             = 4;

  typedef logic [WE_W-1:0] mem_wen_t;

  function automatic int unsigned cnt_width(input int unsigned max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Purpose: one requester's RAM access port.
//   req/we/addr/wdata : request, held stable by the requester until gnt
//   gnt               : request accepted this cycle
//   rvalid/rdata      : read response, one cycle after a granted read
// master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  import ram_arbiter_pkg::*;

  logic          req;
  mem_wen_t      we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/ram_arbiter_starve_cnt.sv
// Purpose: saturating count of consecutive contested m0 grants.
//   clk, rst          : clock, async active-high reset
//   i_m0_contest_win  : both requested and m0 was granted this cycle
//   i_clear           : m1 granted, or m1 not requesting
//   o_force_m1        : count has reached MAX_HOLD, m1 must win next contest
module arb_starve_cnt
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_m0_contest_win,
  input  logic i_clear,
  output logic o_force_m1
);

  localparam int unsigned CW = cnt_width(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Clear wins over increment; saturate at MAX_HOLD.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_m0_contest_win && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_force_m1 = (r_cnt == CNT_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// Purpose: shares a single-port data RAM between the core (m0) and the
// loader/debug port (m1). Fixed priority to m0 with a starvation guard,
// one-cycle read latency tracking and read-data routing.
//   clk, rst     : clock, async active-high reset
//   m0, m1       : requester ports (slave modport)
//   hold_o       : core requested but was not granted (pipeline stall)
//   ram_wen      : RAM byte write enables
//   ram_w_addr   : RAM write address
//   ram_w_data   : RAM write data
//   ram_ren      : RAM read enable
//   ram_r_addr   : RAM read address
//   ram_r_data   : RAM read data, valid one cycle after ram_ren
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  output logic          hold_o,
  output mem_wen_t      ram_wen,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_ren,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data
);

  logic          w_force_m1;
  logic          w_m0_win;
  logic          w_m1_win;
  logic          w_any_win;
  mem_wen_t      w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_rd_grant;
  logic          r_rd_pend;
  logic          r_rd_owner;

  // m0 wins unless m1 is also requesting and has been held off MAX_HOLD times.
  assign w_m0_win  = m0.req & (~m1.req | ~w_force_m1);
  assign w_m1_win  = m1.req & ~w_m0_win;
  assign w_any_win = w_m0_win | w_m1_win;

  assign m0.gnt = w_m0_win;
  assign m1.gnt = w_m1_win;
  assign hold_o = m0.req & ~w_m0_win;

  arb_starve_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_starve_cnt (
    .clk              (clk),
    .rst              (rst),
    .i_m0_contest_win (w_m0_win & m1.req),
    .i_clear          (~m1.req | w_m1_win),
    .o_force_m1       (w_force_m1)
  );

  // Granted requester's payload; all-zero when idle.
  always_comb begin
    w_sel_we    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_m0_win) begin
      w_sel_we    = m0.we;
      w_sel_addr  = m0.addr;
      w_sel_wdata = m0.wdata;
    end else if (w_m1_win) begin
      w_sel_we    = m1.we;
      w_sel_addr  = m1.addr;
      w_sel_wdata = m1.wdata;
    end
  end

  assign w_rd_grant = w_any_win & (w_sel_we == '0);

  assign ram_wen    = w_any_win ? w_sel_we : '0;
  assign ram_w_addr = w_sel_addr;
  assign ram_w_data = w_sel_wdata;
  assign ram_ren    = w_rd_grant;
  assign ram_r_addr = w_sel_addr;

  // One-deep read response tracker; owner only changes on a new read grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= ARB_M0;
    end else begin
      r_rd_pend <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_owner <= w_m1_win ? ARB_M1 : ARB_M0;
      end
    end
  end

  // RAM data arrives in the response cycle; non-owner sees zero.
  assign m0.rvalid = r_rd_pend & (r_rd_owner == ARB_M0);
  assign m1.rvalid = r_rd_pend & (r_rd_owner == ARB_M1);
  assign m0.rdata  = m0.rvalid ? ram_r_data : '0;
  assign m1.rdata  = m1.rvalid ? ram_r_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, checked
// against a behavioural model and a read-response scoreboard.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          MH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold_o;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_ren;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data = '0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  ram_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  ram_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .hold_o     (hold_o),
    .ram_wen    (ram_wen),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_ren    (ram_ren),
    .ram_r_addr (ram_r_addr),
    .ram_r_data (ram_r_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Environment RAM, driven only by the DUT's RAM port.
  logic [31:0] ram_mem [logic [29:0]];
  // Reference memory, updated only by the model's expected writes.
  logic [31:0] ref_mem [logic [29:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_ren) ram_r_data <= ram_mem.exists(ram_r_addr[31:2]) ? ram_mem[ram_r_addr[31:2]] : 32'h0;
    if (ram_wen != 4'h0) begin
      ram_mem[ram_w_addr[31:2]] = merge(ram_mem.exists(ram_w_addr[31:2]) ?
                                        ram_mem[ram_w_addr[31:2]] : 32'h0, ram_w_data, ram_wen);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Pending request per port (requester side).
  logic        pq_req   [2];
  logic [3:0]  pq_we    [2];
  logic [31:0] pq_addr  [2];
  logic [31:0] pq_wdata [2];

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t exp_q[$];

  int streak = 0;      // consecutive contested m0 wins since m1 last got in or dropped
  int m1_grants = 0;

  task automatic arm(input int p, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata);
    pq_req[p] = 1'b1; pq_we[p] = we; pq_addr[p] = addr; pq_wdata[p] = wdata;
  endtask

  task automatic arm_rand(input int p);
    logic [3:0] we;
    we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    arm(p, we, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
  endtask

  task automatic apply();
    m0_if.req = pq_req[0]; m0_if.we = pq_we[0]; m0_if.addr = pq_addr[0]; m0_if.wdata = pq_wdata[0];
    m1_if.req = pq_req[1]; m1_if.we = pq_we[1]; m1_if.addr = pq_addr[1]; m1_if.wdata = pq_wdata[1];
  endtask

  // Expected arbitration outcome and RAM port for the current requests.
  task automatic model_check();
    logic r0, r1;
    int   g;
    rsp_t e;
    r0 = pq_req[0]; r1 = pq_req[1];
    if (r0 && r1)  g = (streak == MH) ? 1 : 0;
    else if (r0)   g = 0;
    else if (r1)   g = 1;
    else           g = -1;
    check("m0_gnt", 64'(m0_if.gnt), 64'(g == 0));
    check("m1_gnt", 64'(m1_if.gnt), 64'(g == 1));
    check("hold_o", 64'(hold_o), 64'(r0 && (g != 0)));
    if (g < 0) begin
      check("idle_wen", 64'(ram_wen), 64'h0);
      check("idle_ren", 64'(ram_ren), 64'h0);
    end else if (pq_we[g] != 4'h0) begin
      check("wr_wen",   64'(ram_wen), 64'(pq_we[g]));
      check("wr_waddr", 64'(ram_w_addr), 64'(pq_addr[g]));
      check("wr_wdata", 64'(ram_w_data), 64'(pq_wdata[g]));
      check("wr_ren",   64'(ram_ren), 64'h0);
      ref_mem[pq_addr[g][31:2]] = merge(ref_mem.exists(pq_addr[g][31:2]) ?
                                        ref_mem[pq_addr[g][31:2]] : 32'h0, pq_wdata[g], pq_we[g]);
    end else begin
      check("rd_ren",   64'(ram_ren), 64'h1);
      check("rd_raddr", 64'(ram_r_addr), 64'(pq_addr[g]));
      check("rd_wen",   64'(ram_wen), 64'h0);
      e.port = g;
      e.data = ref_mem.exists(pq_addr[g][31:2]) ? ref_mem[pq_addr[g][31:2]] : 32'h0;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    if (!r1 || g == 1) streak = 0;
    else if (r0 && g == 0) streak++;
    if (g == 1) m1_grants++;
    if (g >= 0) pq_req[g] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1 apply();
    @(negedge clk);
    model_check();
  endtask

  // Monitor: compare every read response against the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      if (m0_if.rvalid && m1_if.rvalid) check("both_rvalid", 64'h1, 64'h0);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.port == 0) begin
          check("m0_rvalid", 64'(m0_if.rvalid), 64'h1);
          check("m0_rdata",  64'(m0_if.rdata), 64'(e.data));
          check("m1_rdata_idle", 64'(m1_if.rdata), 64'h0);
        end else begin
          check("m1_rvalid", 64'(m1_if.rvalid), 64'h1);
          check("m1_rdata",  64'(m1_if.rdata), 64'(e.data));
          check("m0_rdata_idle", 64'(m0_if.rdata), 64'h0);
        end
      end else begin
        if (m0_if.rvalid) check("m0_spurious_rvalid", 64'h1, 64'h0);
        if (m1_if.rvalid) check("m1_spurious_rvalid", 64'h1, 64'h0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m0_rvalid"}, 64'(m0_if.rvalid), 64'h0);
    check({tag, "_m1_rvalid"}, 64'(m1_if.rvalid), 64'h0);
    check({tag, "_m0_rdata"},  64'(m0_if.rdata), 64'h0);
    check({tag, "_m1_rdata"},  64'(m1_if.rdata), 64'h0);
    check({tag, "_ram_wen"},   64'(ram_wen), 64'h0);
    check({tag, "_ram_ren"},   64'(ram_ren), 64'h0);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    ram_mem[addr[31:2]] = data;
    ref_mem[addr[31:2]] = data;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      pq_req[p] = 1'b0; pq_we[p] = '0; pq_addr[p] = '0; pq_wdata[p] = '0;
    end
    apply();
    rst = 1'b1;
    preload(32'h100, 32'hDEADBEEF);
    preload(32'h0, 32'h11);
    preload(32'h4, 32'h22);
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Single m0 read
    arm(0, 4'h0, 32'h100, 32'h0);
    step(); step();
    // Single m1 partial write
    arm(1, 4'b0011, 32'h204, 32'h1234ABCD);
    step(); step();

    // Continuous contention: 8:1 pattern
    m1_grants = 0;
    for (int i = 0; i < 27; i++) begin
      if (!pq_req[0]) arm_rand(0);
      if (!pq_req[1]) arm_rand(1);
      step();
    end
    check("contention_m1_grants", 64'(m1_grants), 64'd3);
    pq_req[0] = 1'b0; pq_req[1] = 1'b0;
    step(); step();

    // Back-to-back reads
    arm(0, 4'h0, 32'h0, 32'h0);
    arm(1, 4'h0, 32'h4, 32'h0);
    step(); step(); step(); step();

    // m1 drops after 5 contested m0 grants, then rejoins
    for (int i = 0; i < 5; i++) begin
      if (!pq_req[0]) arm_rand(0);
      if (!pq_req[1]) arm_rand(1);
      step();
    end
    pq_req[1] = 1'b0;
    if (!pq_req[0]) arm_rand(0);
    step();
    m1_grants = 0;
    for (int i = 0; i < 8; i++) begin
      if (!pq_req[0]) arm_rand(0);
      if (!pq_req[1]) arm_rand(1);
      step();
    end
    check("rejoin_no_early_force", 64'(m1_grants), 64'd0);
    if (!pq_req[0]) arm_rand(0);
    step();
    check("rejoin_forced", 64'(m1_grants), 64'd1);
    pq_req[0] = 1'b0; pq_req[1] = 1'b0;
    step(); step();

    // Reset right after a granted m0 read
    arm(0, 4'h0, 32'h100, 32'h0);
    step();
    rst = 1'b1;
    exp_q.delete();
    streak = 0;
    pq_req[0] = 1'b0; pq_req[1] = 1'b0;
    apply();
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 check_reset_outputs("midrst_edge");
    @(negedge clk) rst = 1'b0;
    step(); step();
    // Counter must restart from zero: m1 forced on the 9th contest
    m1_grants = 0;
    for (int i = 0; i < 9; i++) begin
      if (!pq_req[0]) arm_rand(0);
      if (!pq_req[1]) arm_rand(1);
      step();
    end
    check("post_reset_force", 64'(m1_grants), 64'd1);
    pq_req[0] = 1'b0; pq_req[1] = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pq_req[p] && $urandom_range(0, 99) < 60) arm_rand(p);
      end
      step();
    end
    pq_req[0] = 1'b0; pq_req[1] = 1'b0;
    step(); step(); step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: m0 = core load/store path (EX/ID), m1 = loader/debug port.
- Fixed priority to m0, with a starvation guard that forces an m1 grant after MAX_HOLD consecutive contested m0 grants.
- Tracks the one-cycle RAM read latency and routes read data back to the requester that issued the read.
- Drives a hold request into the pipeline controller while the core is denied.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 8, consecutive contested m0 grants before m1 is forced; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  core request.
- m0_we  in  4  byte write strobes; 0 means read.
- m0_addr  in  AW  byte address.
- m0_wdata  in  DW  write data.
- m0_gnt  out  1  request accepted this cycle.
- m0_rvalid  out  1  read data valid.
- m0_rdata  out  DW  read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for the loader/debug port.
- hold_o  out  1  to ctrl; stall the pipeline.
- ram_wen  out  4  RAM byte write enables.
- ram_w_addr  out  AW  RAM write address.
- ram_w_data  out  DW  RAM write data.
- ram_ren  out  1  RAM read enable.
- ram_r_addr  out  AW  RAM read address.
- ram_r_data  in  DW  RAM read data, valid one cycle after ram_ren.

Behaviour:
- Arbitration is combinational, one grant per cycle, and at most one of m0_gnt/m1_gnt is high.
  - Only one requester active: that requester is granted.
  - Both active: m0 wins unless starve_cnt == MAX_HOLD, in which case m1 wins.
  - Neither active: no grant; ram_wen=0, ram_ren=0.
- starve_cnt, width $clog2(MAX_HOLD+1), registered:
  - Increments on a cycle where both request and m0 wins.
  - Clears on any m1 grant, or on any cycle with m1_req=0.
  - Holds otherwise.
  - Never exceeds MAX_HOLD.
- Granted write (we!=0):
  - ram_wen=we; ram_w_addr=addr; ram_w_data=wdata; ram_ren=0.
  - No rvalid is produced.
- Granted read (we==0):
  - ram_ren=1; ram_r_addr=addr; ram_wen=0.
  - Registered rd_owner/rd_pend capture the requester.
  - Next cycle, that requester's rvalid=1 and its rdata=ram_r_data.
  - The other requester's rdata=0.
- Read latency is exactly 1 cycle. A read may be granted every cycle (back-to-back); the response pipeline is one deep, with no backpressure.
- The same-cycle response to a previous read and a new grant are independent. A new write in the response cycle does not corrupt the returned data.
- When a requester is not granted, ram_* outputs carry the granted requester's values, or 0 when idle.
- hold_o = m0_req & ~m0_gnt, combinational.
- The requester must keep req/we/addr/wdata stable until gnt.
- Reset (async assert, sync release):
  - starve_cnt=0, rd_pend=0, rd_owner=m0.
  - All registered outputs are 0: m*_rvalid=0, m*_rdata=0.
  - A read pending when reset asserts is dropped and produces no rvalid after release.
- MAX_HOLD=1: strict alternation under continuous contention.

Decomposition:
- Shared defines file, using the team's `define style alongside `RegBus: `ARB_M0=1'b0, `ARB_M1=1'b1, `ARB_MAX_HOLD default, `MemWenBus [3:0].
- One natural sub-module, arb_starve_cnt: saturating contested-grant counter with clear, outputting force_m1.
- Read-response tracking and muxing stay in ram_arbiter.

Test Plan:
- m0 read only, addr 0x100, RAM holds 0xDEADBEEF -> m0_gnt same cycle; ram_ren=1, ram_r_addr=0x100; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1_rvalid=0.
- m1 write only, we=4'b0011, addr 0x204, data 0x1234ABCD -> m1_gnt=1, ram_wen=4'b0011, ram_w_data=0x1234ABCD, ram_ren=0, no rvalid; hold_o=0.
- Both request continuously, MAX_HOLD=8 -> m0 granted 8 cycles, m1 granted on the 9th, then repeat (pattern 8:1). hold_o=1 exactly on each m1-grant cycle.
- Back-to-back reads m0@0x0 then m1@0x4 (contents 0x11, 0x22) -> m0_rvalid/0x11 in cycle 2, m1_rvalid/0x22 in cycle 3; never both rvalid in one cycle.
- m1_req drops after 5 contested m0 grants, then rises again -> starve_cnt clears; m1 forced only after 8 fresh contested m0 grants.
- Assert rst for 1 cycle immediately after a granted m0 read -> no m0_rvalid after release; all outputs 0; starve_cnt=0.
